spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
Parametrised SPI slave receiver that replaces the free-running 128-bit shift register with a framed, clk-domain receiver. It synchronises sck/sdi/ce into clk, shifts MSB-first while ce is asserted, and validates the bit count when ce deasserts. Complete frames are published as NUM_CH words of CH_WIDTH bits with a valid/ack handshake. It sits between the MCU SPI pins and the downstream consumer logic (e.g. pwm generation) in top.

Parameters:
NUM_CH, 4, number of channel words per frame
CH_WIDTH, 32, bits per channel word
SYNC_STAGES, 2, flip-flops in each input synchroniser (min 2)
FRAME_BITS is local: NUM_CH*CH_WIDTH (default 128)

Ports:
clk  in  1  system clock; must be >= 4x sck frequency
reset_n  in  1  asynchronous active-low reset
sck  in  1  SPI clock, CPOL=0/CPHA=0, async to clk
sdi  in  1  SPI data in, async to clk
ce  in  1  chip enable, active-high, async to clk
frame_data  out  FRAME_BITS  last good frame; channel k = bits [(k+1)*CH_WIDTH-1 : k*CH_WIDTH], channel NUM_CH-1 is the first word shifted in
frame_valid  out  1  held high from frame publish until acked
frame_ack  in  1  consumer accepts frame_data
frame_err  out  1  one-cycle pulse: frame ended with wrong bit count
overrun  out  1  one-cycle pulse: good frame overwrote an unacked frame
frame_cnt  out  8  count of good frames published, wraps 255->0

Behaviour:
- Clock is clk; reset is asynchronous and active-low (reset_n). No logic clocked by sck.
- Reset values: frame_data=0, frame_valid=0, frame_err=0, overrun=0, frame_cnt=0, shift reg=0, bit count=0, state=IDLE, synchroniser flops=0.
- sck, sdi, ce each pass through SYNC_STAGES flops; one extra flop on synced sck and ce for edge detect. sdi sampled from its synced stage on the cycle a synced sck rising edge is detected.
- States:
  - IDLE: waiting for synced ce rising edge -> SHIFT; clear bit count and shift reg. If ce is already high when leaving reset, stay in IDLE until ce falls and rises again.
  - SHIFT: on each sck rising edge shift reg <= {shift reg[FRAME_BITS-2:0], sdi}; bit count increments, saturating at FRAME_BITS+1 (width clog2(FRAME_BITS+2)). sck edges outside SHIFT ignored. On synced ce falling edge -> CHECK.
  - CHECK (one cycle): bit count == FRAME_BITS -> publish; else pulse frame_err, frame_data/frame_valid unchanged. Always -> IDLE.
- Publish (cycle after CHECK): frame_data <= shift reg, frame_valid <= 1, frame_cnt += 1. If frame_valid was already 1 and frame_ack is not high in that same cycle, pulse overrun (new data still published).
- Handshake: frame_valid clears the cycle after frame_ack high while frame_valid=1. frame_ack while frame_valid=0 has no effect. Simultaneous ack and publish: publish wins, frame_valid stays 1, no overrun.
- Latency: frame_valid rises at most SYNC_STAGES+3 clk cycles after ce falls at pin.
- ce falling with zero bits, short frames and long frames (> FRAME_BITS, saturated count) all give frame_err.
- reset_n low mid-frame: everything returns to reset values immediately; partial frame discarded.

Test Plan:
- Defaults; ce high, shift 128 bits 0x00112233_44556677_8899AABB_CCDDEEFF, ce low -> frame_valid=1 within 5 clks, channel 3=0x00112233, channel 0=0xCCDDEEFF, frame_cnt=1, frame_err=0.
- Frame of 127 bits, then 129 bits -> frame_err pulses twice (1 cycle each), frame_data and frame_cnt unchanged from prior frame.
- Two good frames (0xA5 repeating, then 0x5A repeating) with no ack -> overrun pulses once, frame_data=0x5A..5A, frame_cnt=2; frame_ack 1 cycle -> frame_valid=0 next cycle.
- Ack asserted in the exact publish cycle of a second frame -> frame_valid stays 1, overrun=0.
- reset_n low after 64 bits, release with ce still high, finish the 64 bits, drop ce -> no frame_valid, no frame_err; next full frame 0xFFFF..FF publishes normally, frame_cnt=1.
- 50 sck pulses with ce low, then NUM_CH=2, CH_WIDTH=16 build, 32-bit frame 0xDEADBEEF -> ignored edges give no activity; channel 1=0xDEAD, channel 0=0xBEEF.

Source files
------------

// File: rtl/spi_frame_rx.sv
// Framed SPI slave receiver (CPOL=0/CPHA=0) sampled entirely in the clk domain.
// Publishes NUM_CH words of CH_WIDTH bits per good frame through a valid/ack handshake.
module spi_frame_rx #(
  parameter int NUM_CH      = 4,
  parameter int CH_WIDTH    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sck,
  input  logic                         sdi,
  input  logic                         ce,
  output logic [NUM_CH*CH_WIDTH-1:0]   frame_data,
  output logic                         frame_valid,
  input  logic                         frame_ack,
  output logic                         frame_err,
  output logic                         overrun,
  output logic [7:0]                   frame_cnt
);

  localparam int FRAME_BITS = NUM_CH * CH_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int WARM_W     = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_BITS + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] sdi_sync_reg;
  logic [SYNC_STAGES-1:0] ce_sync_reg;
  logic                   sck_d_reg;
  logic                   ce_d_reg;
  logic [WARM_W-1:0]      warm_reg;

  state_t                 state_reg;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;

  logic sck_s, sdi_s, ce_s;
  logic warm_done;
  logic sck_rise, ce_rise, ce_fall;

  assign sck_s     = sck_sync_reg[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_reg[SYNC_STAGES-1];
  assign ce_s      = ce_sync_reg[SYNC_STAGES-1];
  assign warm_done = (warm_reg == WARM_DONE);

  assign sck_rise = sck_s & ~sck_d_reg;
  // Until the pipeline has flushed, a 0->1 on synced ce only reflects reset
  // values, so a ce held high through reset must be toggled before a frame starts.
  assign ce_rise  = ce_s & ~ce_d_reg & warm_done;
  assign ce_fall  = ~ce_s & ce_d_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_reg <= '0;
      sdi_sync_reg <= '0;
      ce_sync_reg  <= '0;
      sck_d_reg    <= 1'b0;
      ce_d_reg     <= 1'b0;
      warm_reg     <= '0;
    end else begin
      sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
      sdi_sync_reg <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi};
      ce_sync_reg  <= {ce_sync_reg[SYNC_STAGES-2:0], ce};
      sck_d_reg    <= sck_s;
      ce_d_reg     <= ce_s;
      if (!warm_done) warm_reg <= warm_reg + WARM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (frame_valid && frame_ack) frame_valid <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (ce_rise) begin
            state_reg   <= SHIFT;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_s};
            if (bit_cnt_reg != CNT_SAT) bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
          if (ce_fall) state_reg <= CHECK;
        end
        CHECK: begin
          state_reg <= IDLE;
          if (bit_cnt_reg == CNT_FULL) begin
            // A publish overrides a same-cycle ack clearing frame_valid.
            frame_data  <= shift_reg;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
            overrun     <= frame_valid & ~frame_ack;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomised bench for spi_frame_rx: bit-level SPI stimulus checked against a
// frame-level model (bit count, expected word, handshake bookkeeping).
module tb_spi_frame_rx;

  localparam int S   = 2;
  localparam int FB  = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sck = 1'b0, sdi = 1'b0, ce = 1'b0, ce2 = 1'b0;
  logic frame_ack = 1'b0, frame_ack2 = 1'b0;

  logic [FB-1:0] frame_data;
  logic          frame_valid, frame_err, overrun;
  logic [7:0]    frame_cnt;
  logic [31:0]   frame_data2;
  logic          frame_valid2, frame_err2, overrun2;
  logic [7:0]    frame_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0, ovr_seen = 0, err2_seen = 0, ovr2_seen = 0;

  // Frame-level reference state
  logic [FB-1:0] m_data;
  bit            m_valid;
  int            m_cnt, m_err, m_ovr;

  spi_frame_rx #(.NUM_CH(4), .CH_WIDTH(32), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .ce(ce),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .frame_err(frame_err), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  spi_frame_rx #(.NUM_CH(2), .CH_WIDTH(16), .SYNC_STAGES(S)) dut2 (
    .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .ce(ce2),
    .frame_data(frame_data2), .frame_valid(frame_valid2), .frame_ack(frame_ack2),
    .frame_err(frame_err2), .overrun(overrun2), .frame_cnt(frame_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err)  err_seen  <= err_seen + 1;
    if (overrun)    ovr_seen  <= ovr_seen + 1;
    if (frame_err2) err2_seen <= err2_seen + 1;
    if (overrun2)   ovr2_seen <= ovr2_seen + 1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"},  frame_data,  m_data);
    check({tag, ".valid"}, frame_valid, m_valid);
    check({tag, ".cnt"},   frame_cnt,   m_cnt[7:0]);
    check({tag, ".errs"},  err_seen,    m_err);
    check({tag, ".ovrs"},  ovr_seen,    m_ovr);
  endtask

  // MSB-first: v[n-1] goes out first; sck period = 4 clk.
  task automatic shift_bits(input logic [255:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      sck = 1'b0;
      repeat (2) @(negedge clk);
      sck = 1'b1;
      repeat (2) @(negedge clk);
    end
    sck = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [255:0] v, input int n, input bit which, input bit ack_pub);
    if (which) ce2 = 1'b1; else ce = 1'b1;
    repeat (S + 3) @(negedge clk);
    shift_bits(v, n);
    if (which) ce2 = 1'b0; else ce = 1'b0;
    // Publish happens on the (S+2)th edge after the pin drops; ack covers exactly that edge.
    repeat (S + 1) @(negedge clk);
    if (ack_pub) frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    @(negedge clk);
    if (!which) begin
      if (n == FB) begin
        if (m_valid && !ack_pub) m_ovr++;
        m_data  = v[FB-1:0];
        m_valid = 1'b1;
        m_cnt   = (m_cnt + 1) % 256;
      end else begin
        m_err++;
        if (ack_pub) m_valid = 1'b0;
      end
    end
  endtask

  task automatic ack_pulse(input string tag);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    m_valid = 1'b0;
    check({tag, ".valid_after_ack"}, frame_valid, m_valid);
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 1'b0; m_cnt = 0;
  endtask

  initial begin
    logic [255:0] v;
    int n, r;
    bit ap;

    model_reset();
    m_err = 0; m_ovr = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset.data", frame_data, '0);
    check("reset.valid", frame_valid, 1'b0);
    check("reset.err", frame_err, 1'b0);
    check("reset.ovr", overrun, 1'b0);
    check("reset.cnt", frame_cnt, 8'd0);

    // Directed 128-bit frame; valid sampled S+3 cycles after ce drop
    v = {128'h0, 128'h00112233_44556677_8899AABB_CCDDEEFF};
    send_frame(v, FB, 1'b0, 1'b0);
    check_model("t1");
    check("t1.ch3", frame_data[127:96], 32'h00112233);
    check("t1.ch0", frame_data[31:0], 32'hCCDDEEFF);

    // Short and long frames
    send_frame({8{32'h1234_5678}}, 127, 1'b0, 1'b0);
    send_frame({8{32'h8765_4321}}, 129, 1'b0, 1'b0);
    check_model("t2");

    // Two unacked good frames
    ack_pulse("t3pre");
    send_frame({32{8'hA5}}, FB, 1'b0, 1'b0);
    send_frame({32{8'h5A}}, FB, 1'b0, 1'b0);
    check_model("t3");
    ack_pulse("t3");

    // Ack landing exactly on the publish edge
    send_frame({8{32'hC0FF_EE00}}, FB, 1'b0, 1'b0);
    send_frame({8{32'h0BAD_F00D}}, FB, 1'b0, 1'b1);
    check_model("t4");

    // Reset mid-frame with ce held high across release
    ce = 1'b1;
    repeat (S + 3) @(negedge clk);
    shift_bits({8{32'hFEED_BEEF}}, 64);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t5.async_data", frame_data, '0);
    check("t5.async_valid", frame_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    shift_bits({8{32'hFEED_BEEF}}, 64);
    ce = 1'b0;
    repeat (S + 5) @(negedge clk);
    check_model("t5.discard");
    send_frame({256{1'b1}}, FB, 1'b0, 1'b0);
    check_model("t5");

    // sck activity with both chip enables low
    for (int i = 0; i < 50; i++) begin
      sdi = i[0];
      sck = 1'b1; repeat (2) @(negedge clk);
      sck = 1'b0; repeat (2) @(negedge clk);
    end
    repeat (S + 3) @(negedge clk);
    check_model("t6.idle");
    check("t6.valid2_idle", frame_valid2, 1'b0);
    check("t6.errs2_idle", err2_seen, 0);

    // Narrow build: 2 x 16-bit channels
    send_frame({224'h0, 32'hDEADBEEF}, 32, 1'b1, 1'b0);
    check("t6.ch1", frame_data2[31:16], 16'hDEAD);
    check("t6.ch0", frame_data2[15:0], 16'hBEEF);
    check("t6.valid2", frame_valid2, 1'b1);
    check("t6.cnt2", frame_cnt2, 8'd1);
    check("t6.errs2", err2_seen, 0);
    check("t6.ovrs2", ovr2_seen, 0);
    check_model("t6.main");

    // Randomised frames: mostly good, some zero/short/long/saturating
    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(0, 9);
      n = (r < 6) ? FB : (r == 6) ? 0 : (r == 7) ? FB - 1 : (r == 8) ? FB + 1
          : $urandom_range(FB + 2, 200);
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ap = ($urandom_range(0, 3) == 0);
      send_frame(v, n, 1'b0, ap);
      check_model($sformatf("rnd%0d.n%0d", it, n));
      if ($urandom_range(0, 2) == 0) ack_pulse($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
